// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data extraction, writeback source select,
// a forwarding copy of the committed result and a retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [XLEN-1:0]  in_imm,
    output logic [4:0]       waddr,
    output logic [XLEN-1:0]  wdata,
    output logic             regWrite,
    output logic             wb_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             fwd_en,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // Sign- or zero-extend a loaded byte/half to the full datapath width.
    function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [XLEN-1:0] s;
        s = XLEN'(signed'(b));
        return sgn ? s : {{(XLEN-8){1'b0}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [XLEN-1:0] s;
        s = XLEN'(signed'(h));
        return sgn ? s : {{(XLEN-16){1'b0}}, h};
    endfunction

    logic [1:0]       off;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  wb_data;
    logic             we_next;

    logic             valid_q,   valid_d;
    logic [4:0]       waddr_q,   waddr_d;
    logic [XLEN-1:0]  wdata_q,   wdata_d;
    logic             we_q,      we_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    assign off = in_alu_result[1:0];

    always_comb begin
        byte_sel = in_mem_rdata[7:0];
        case (off)
            2'd0: byte_sel = in_mem_rdata[7:0];
            2'd1: byte_sel = in_mem_rdata[15:8];
            2'd2: byte_sel = in_mem_rdata[23:16];
            2'd3: byte_sel = in_mem_rdata[31:24];
            default: byte_sel = in_mem_rdata[7:0];
        endcase
        half_sel = off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    end

    // Unknown load encodings fall back to the full word.
    always_comb begin
        load_data = in_mem_rdata;
        case (in_funct3)
            F3_LB:   load_data = ext_byte(byte_sel, 1'b1);
            F3_LBU:  load_data = ext_byte(byte_sel, 1'b0);
            F3_LH:   load_data = ext_half(half_sel, 1'b1);
            F3_LHU:  load_data = ext_half(half_sel, 1'b0);
            default: load_data = in_mem_rdata;
        endcase
    end

    always_comb begin
        wb_data = in_imm;
        case (in_wb_sel)
            WB_ALU:  wb_data = in_alu_result;
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = in_pc_plus4;
            default: wb_data = in_imm;
        endcase
    end

    assign we_next = in_valid & in_reg_write & (in_rd != 5'd0);

    // Flush beats stall; stall freezes everything including the counter.
    always_comb begin
        valid_d   = valid_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        instret_d = instret_q;
        if (flush) begin
            valid_d = 1'b0;
            waddr_d = 5'd0;
            wdata_d = '0;
            we_d    = 1'b0;
        end else if (!stall) begin
            valid_d   = in_valid;
            waddr_d   = in_rd;
            wdata_d   = wb_data;
            we_d      = we_next;
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q   <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            instret_q <= instret_d;
        end
    end

    assign wb_valid = valid_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign regWrite = we_q;
    assign instret  = instret_q;

    assign fwd_rd   = waddr_q;
    assign fwd_data = wdata_q;
    assign fwd_en   = we_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against an arithmetic reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rstn, stall, flush;
    logic        in_valid, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;

    logic [4:0]  waddr, fwd_rd;
    logic [31:0] wdata, fwd_data, instret;
    logic        regWrite, wb_valid, fwd_en;

    logic [4:0]  waddr_s, fwd_rd_s;
    logic [31:0] wdata_s, fwd_data_s;
    logic        regWrite_s, wb_valid_s, fwd_en_s;
    logic [3:0]  instret_s;

    int n_cmp = 0;
    int n_err = 0;

    logic        m_valid, m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
        .waddr(waddr), .wdata(wdata), .regWrite(regWrite), .wb_valid(wb_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_en(fwd_en), .instret(instret)
    );

    mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut_small (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
        .waddr(waddr_s), .wdata(wdata_s), .regWrite(regWrite_s), .wb_valid(wb_valid_s),
        .fwd_rd(fwd_rd_s), .fwd_data(fwd_data_s), .fwd_en(fwd_en_s), .instret(instret_s)
    );

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Load result computed from shifts and two's-complement offsets.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int unsigned off,
                                             input logic [2:0] f3);
        int unsigned b, h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] ref_src();
        case (in_wb_sel)
            2'd0: return in_alu_result;
            2'd1: return ref_load(in_mem_rdata, int'(in_alu_result[1:0]), in_funct3);
            2'd2: return in_pc_plus4;
            default: return in_imm;
        endcase
    endfunction

    task automatic model_edge();
        if (!rstn) begin
            m_valid = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_waddr = in_rd;
            m_wdata = ref_src();
            m_we    = in_valid && in_reg_write && (in_rd != 0);
            m_cnt   = m_cnt + (in_valid ? 1 : 0);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, m_valid});
        chk({tag, ".waddr"},    {27'd0, waddr},    {27'd0, m_waddr});
        chk({tag, ".wdata"},    wdata,             m_wdata);
        chk({tag, ".regWrite"}, {31'd0, regWrite}, {31'd0, m_we});
        chk({tag, ".fwd_rd"},   {27'd0, fwd_rd},   {27'd0, m_waddr});
        chk({tag, ".fwd_data"}, fwd_data,          m_wdata);
        chk({tag, ".fwd_en"},   {31'd0, fwd_en},   {31'd0, m_we});
        chk({tag, ".instret"},  instret,           m_cnt);
        chk({tag, ".instret4"}, {28'd0, instret_s}, m_cnt & 32'hF);
    endtask

    task automatic set_in(input logic v, input logic rw, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] rdat, input logic [31:0] pc4, input logic [31:0] imm);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
        in_alu_result = alu; in_mem_rdata = rdat; in_pc_plus4 = pc4; in_imm = imm;
    endtask

    task automatic rand_in();
        set_in(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
               $urandom, $urandom, $urandom, $urandom);
    endtask

    initial begin
        m_valid = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
        rstn = 0; stall = 0; flush = 0;
        set_in(1, 1, 5'd7, 2'd0, 3'd2, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1111_2222, 32'h3333_4444);

        step("rst0");
        step("rst1");
        chk("rst.wdata0", wdata, 32'h0);
        chk("rst.instret0", instret, 32'h0);

        rstn = 1;
        set_in(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
        step("alu");
        chk("alu.wdata_c", wdata, 32'h1234_5678);
        chk("alu.instret_c", instret, 32'd1);

        set_in(1, 1, 5'd6, 2'd1, 3'd0, 32'h1, 32'h80FF_7F01, 32'h0, 32'h0);
        step("lb1");  chk("lb1.c", wdata, 32'h0000_007F);
        in_alu_result = 32'h2;
        step("lb2");  chk("lb2.c", wdata, 32'hFFFF_FFFF);
        in_funct3 = 3'd4; in_alu_result = 32'h3;
        step("lbu3"); chk("lbu3.c", wdata, 32'h0000_0080);
        in_funct3 = 3'd1; in_alu_result = 32'h2;
        step("lh2");  chk("lh2.c", wdata, 32'hFFFF_80FF);
        in_funct3 = 3'd5; in_alu_result = 32'h0;
        step("lhu0"); chk("lhu0.c", wdata, 32'h0000_7F01);
        in_funct3 = 3'd2; in_alu_result = 32'h3;
        step("lw3");  chk("lw3.c", wdata, 32'h80FF_7F01);
        in_funct3 = 3'd7;
        step("f3_7"); chk("f3_7.c", wdata, 32'h80FF_7F01);

        set_in(1, 1, 5'd0, 2'd3, 3'd0, 32'h0, 32'h0, 32'h0, 32'hABCD_E000);
        step("rd0");  chk("rd0.we_c", {31'd0, regWrite}, 32'd0);
        in_valid = 0; in_rd = 5'd9;
        step("inv");  chk("inv.we_c", {31'd0, regWrite}, 32'd0);

        set_in(1, 1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0010, 32'h0);
        step("pc4");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            step("stall");
            chk("stall.wdata_c", wdata, 32'h10);
            chk("stall.waddr_c", {27'd0, waddr}, 32'd1);
        end
        flush = 1;
        step("stfl"); chk("stfl.we_c", {31'd0, regWrite}, 32'd0);
        flush = 0; stall = 0;

        set_in(1, 1, 5'd3, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0, 32'h0);
        step("pre_mrst");
        stall = 1; rstn = 0;
        step("mrst");
        stall = 0; rstn = 1;

        for (int i = 0; i < 17; i++) begin
            rand_in(); in_valid = 1;
            step("wrap");
        end
        chk("wrap.instret4_c", {28'd0, instret_s}, 32'd1);
        chk("wrap.instret_c", instret, 32'd17);

        for (int i = 0; i < 300; i++) begin
            rand_in();
            rstn  = ($urandom_range(0, 39) != 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the pipelined CPU.
- Captures the MEM-stage result bundle and performs load-data byte/half extraction and sign/zero extension.
- Selects the writeback source and drives the register file write port (waddr/wdata/regWrite) one cycle later.
- Also provides a forwarding copy of the result and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- stall  in  1  hold all stage state; ignore inputs.
- flush  in  1  insert a bubble (valid=0) at the next edge.
- in_valid  in  1  MEM-stage instruction valid.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_wb_sel  in  2  00=ALU, 01=load data, 10=PC+4, 11=immediate (LUI).
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_alu_result  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- in_mem_rdata  in  XLEN  raw aligned word from data memory.
- in_pc_plus4  in  XLEN  PC+4 of the instruction.
- in_imm  in  XLEN  U-type immediate.
- waddr  out  5  register file write address.
- wdata  out  XLEN  register file write data.
- regWrite  out  1  register file write enable.
- wb_valid  out  1  WB-stage slot holds a valid instruction.
- fwd_rd  out  5  forwarding destination (equals waddr).
- fwd_data  out  XLEN  forwarding data (equals wdata).
- fwd_en  out  1  forwarding enable (equals regWrite).
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rstn=0 at posedge): wb_valid, waddr, wdata, regWrite, the fwd_* outputs and instret all go to 0. Reset has priority over stall and flush. A reset mid-stall discards the held instruction.
- Priority at each posedge: rstn=0 > flush > stall > normal capture.
- flush=1: wb_valid<=0, regWrite<=0, waddr<=0, wdata<=0. instret unchanged. Flush overrides stall.
- stall=1 (flush=0): every register holds its value. regWrite stays asserted if it was asserted, so the register file rewrites the same value (idempotent). instret does not increment.
- Normal capture: all outputs are registered, with 1-cycle latency from inputs to outputs.
  - wb_valid <= in_valid.
  - waddr <= in_rd.
  - regWrite <= in_valid & in_reg_write & (in_rd != 0).
- Load extraction (combinational before the register; off = in_alu_result[1:0]):
  - LB/LBU: byte = in_mem_rdata[8*off+7 : 8*off]; sign-extend for LB, zero-extend for LBU.
  - LH/LHU: half = off[1] ? rdata[31:16] : rdata[15:0]; off[0] is ignored; sign-extend for LH, zero-extend for LHU.
  - LW, and undefined funct3 (011, 110, 111): full word; off is ignored.
- wdata <= the source selected by in_wb_sel. in_funct3 is used only when in_wb_sel=01.
- When in_valid=0 on a capture edge: wdata and waddr are still captured (don't-care values), but regWrite=0.
- instret increments by 1 on each capture edge with in_valid=1. It wraps modulo 2^CNT_W without saturating.
- fwd_rd/fwd_data/fwd_en are wire copies of waddr/wdata/regWrite, with no extra latency.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with in_valid=1 and garbage inputs -> all outputs 0, instret=0. Release -> first capture appears the next cycle.
- ALU writeback: in_valid=1, rd=5, reg_write=1, wb_sel=00, alu=0x1234_5678 -> next cycle waddr=5, wdata=0x12345678, regWrite=1, instret=1.
- Loads with rdata=0x80FF_7F01:
  - LB off=1 -> 0x0000007F.
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW off=3 -> 0x80FF7F01.
- rd=0 / invalid: rd=0 with reg_write=1 -> regWrite=0, instret still increments. in_valid=0 -> regWrite=0, wb_valid=0, instret unchanged.
- Stall/flush:
  - Latch a PC+4 writeback (pc_plus4=0x0000_0010, rd=1), then stall 3 cycles while inputs change -> outputs hold 0x10/rd=1, instret unchanged.
  - Assert stall=1 and flush=1 together -> regWrite=0, wb_valid=0.
- Counter wrap (CNT_W=4): retire 17 valid instructions -> instret=1.
